// File: rtl/id_ex_hazard_ctrl_if.sv
// Signal bundle between the ID/EX hazard controller and the pipeline.
// Inputs come from ID/EX fields and data memory; outputs steer the stage registers.
interface id_ex_hazard_ctrl_if #(
    parameter int CNT_W = 16
) ();
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rt;
    logic             ex_branch_taken;
    logic             mem_busy;
    logic             clr_stats;
    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             id_ex_hold;
    logic             ex_mem_hold;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
        output ex_branch_taken, mem_busy, clr_stats,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
        input  id_ex_hold, ex_mem_hold, ctrl_state, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt,
        input  ex_branch_taken, mem_busy, clr_stats,
        output pc_stall, if_id_stall, if_id_flush, id_ex_bubble,
        output id_ex_hold, ex_mem_hold, ctrl_state, stall_cycles
    );
endinterface

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard and sequencing control: load-use bubbles, branch flush,
// memory-busy freeze and a saturating stall-cycle counter.
module id_ex_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input logic               clk,
    input logic               rst_n,
    id_ex_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_RUN = 2'd0,
        S_LU  = 2'd1,
        S_FRZ = 2'd2
    } state_t;

    localparam logic [2:0] LU_INIT = 3'(LOAD_STALL_CYCLES - 1);

    state_t           r_state;
    state_t           r_ret;
    state_t           w_next;
    state_t           w_ret_next;
    state_t           w_eff;
    logic [2:0]       r_lu_cnt;
    logic [2:0]       w_lu_cnt_next;
    logic [CNT_W-1:0] r_stall_cycles;
    logic             w_lu_haz;
    logic             w_stall;
    logic             w_flush;
    logic             w_bubble;
    logic             w_hold;

    assign w_lu_haz = bus.ex_mem_read & (bus.ex_rt != 5'd0) &
                      ((bus.ex_rt == bus.id_rs) |
                       (bus.id_uses_rt & (bus.ex_rt == bus.id_rt)));

    // Leaving a freeze resumes exactly where the pipeline was held.
    assign w_eff = (r_state == S_FRZ) ? r_ret : r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_RUN;
            r_ret    <= S_RUN;
            r_lu_cnt <= 3'd0;
        end else begin
            r_state  <= w_next;
            r_ret    <= w_ret_next;
            r_lu_cnt <= w_lu_cnt_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_ret_next    = r_ret;
        w_lu_cnt_next = r_lu_cnt;
        if (bus.mem_busy) begin
            w_next = S_FRZ;
            if (r_state != S_FRZ)
                w_ret_next = r_state;
        end else if (bus.ex_branch_taken) begin
            w_next        = S_RUN;
            w_lu_cnt_next = 3'd0;
        end else if (w_eff == S_LU) begin
            w_lu_cnt_next = r_lu_cnt - 3'd1;
            w_next        = (r_lu_cnt == 3'd1) ? S_RUN : S_LU;
        end else if (w_lu_haz && (LOAD_STALL_CYCLES > 1)) begin
            w_next        = S_LU;
            w_lu_cnt_next = LU_INIT;
        end else begin
            w_next = S_RUN;
        end
    end

    always_comb begin
        w_stall  = 1'b0;
        w_flush  = 1'b0;
        w_bubble = 1'b0;
        w_hold   = 1'b0;
        if (bus.mem_busy) begin
            w_stall = 1'b1;
            w_hold  = 1'b1;
        end else if (bus.ex_branch_taken) begin
            w_flush  = 1'b1;
            w_bubble = 1'b1;
        end else if ((w_eff == S_LU) || w_lu_haz) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cycles <= '0;
        else if (bus.clr_stats)
            r_stall_cycles <= '0;
        else if (w_stall && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end

    // Reset must silence every control line even before the first edge.
    assign bus.pc_stall     = rst_n & w_stall;
    assign bus.if_id_stall  = rst_n & w_stall;
    assign bus.if_id_flush  = rst_n & w_flush;
    assign bus.id_ex_bubble = rst_n & w_bubble;
    assign bus.id_ex_hold   = rst_n & w_hold;
    assign bus.ex_mem_hold  = rst_n & w_hold;
    assign bus.ctrl_state   = r_state;
    assign bus.stall_cycles = r_stall_cycles;
endmodule
